// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : next-PC select plus IF/ID and ID/EX stall/flush control
// Revision 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             mem_stall_i,
   input  logic             load_use_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_target_i,
   input  logic [31:0]      pc_i,
   output logic [31:0]      pc_next_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_stall_o,
   output logic             redirect_pending_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_MSTALL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   state_t           r_state;
   logic             r_pending;
   logic [31:0]      r_target;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   state_t           w_next_state;
   logic             w_next_pending;
   logic [31:0]      w_next_target;
   logic             w_stall_inc;
   logic             w_flush_inc;

   always_comb begin
      pc_next_o      = pc_i + 32'd4;
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      pipe_stall_o   = 1'b0;
      w_next_state   = r_state;
      w_next_pending = r_pending;
      w_next_target  = r_target;
      w_stall_inc    = 1'b0;
      w_flush_inc    = 1'b0;

      case (r_state)
         S_RUN, S_MSTALL: begin
            if (mem_stall_i) begin
               pipe_stall_o = 1'b1;
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               w_stall_inc  = 1'b1;
               w_next_state = S_MSTALL;
               if (branch_taken_i) begin
                  w_next_pending = 1'b1;
                  w_next_target  = branch_target_i;
               end
            end else if (r_pending) begin
               // Release of a latched redirect; a fresh pulse is younger and wins.
               // The flush kills the ID instruction, so load_use is irrelevant here.
               pc_next_o      = branch_taken_i ? branch_target_i : r_target;
               ifid_flush_o   = 1'b1;
               w_flush_inc    = 1'b1;
               w_next_pending = 1'b0;
               w_next_state   = S_RUN;
            end else begin
               w_next_state = S_RUN;
               if (load_use_i) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_bubble_o = 1'b1;
               end
               if (branch_taken_i) begin
                  pc_next_o    = branch_target_i;
                  pc_write_o   = 1'b1;
                  ifid_flush_o = 1'b1;
                  w_flush_inc  = 1'b1;
               end
            end
         end
         default: begin
            pc_next_o    = RESET_PC;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            w_next_state = start_i ? S_RUN : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_pending   <= 1'b0;
         r_target    <= 32'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state   <= w_next_state;
         r_pending <= w_next_pending;
         r_target  <= w_next_target;
         if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush_inc && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign redirect_pending_o = r_pending;
   assign stall_cnt_o        = r_stall_cnt;
   assign flush_cnt_o        = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed plus randomized checks against a behavioural model
// Revision 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   localparam int          CNT_W    = 16;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam longint      CNT_MAX  = (longint'(1) << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             mem_stall_i = 1'b0;
   logic             load_use_i = 1'b0;
   logic             branch_taken_i = 1'b0;
   logic [31:0]      branch_target_i = 32'd0;
   logic [31:0]      pc_i = 32'd0;
   logic [31:0]      pc_next_o;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             pipe_stall_o;
   logic             redirect_pending_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: running flag, outstanding redirect, saturating counters
   bit          m_started;
   bit          m_pending;
   logic [31:0] m_saved;
   longint      m_stall;
   longint      m_flush;
   logic [31:0] e_pc_next;
   logic [4:0]  e_ctrl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall}

   pc_sequencer #(
      .RESET_PC (RESET_PC),
      .CNT_W    (CNT_W)
   ) u_dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .start_i            (start_i),
      .mem_stall_i        (mem_stall_i),
      .load_use_i         (load_use_i),
      .branch_taken_i     (branch_taken_i),
      .branch_target_i    (branch_target_i),
      .pc_i               (pc_i),
      .pc_next_o          (pc_next_o),
      .pc_write_o         (pc_write_o),
      .ifid_write_o       (ifid_write_o),
      .ifid_flush_o       (ifid_flush_o),
      .idex_bubble_o      (idex_bubble_o),
      .pipe_stall_o       (pipe_stall_o),
      .redirect_pending_o (redirect_pending_o),
      .stall_cnt_o        (stall_cnt_o),
      .flush_cnt_o        (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic void model_reset();
      m_started = 1'b0;
      m_pending = 1'b0;
      m_saved   = 32'd0;
      m_stall   = 0;
      m_flush   = 0;
   endfunction

   function automatic void model_outputs();
      logic pw, iw, fl, bb, st;
      pw = 1'b1; iw = 1'b1; fl = 1'b0; bb = 1'b0; st = 1'b0;
      e_pc_next = pc_i + 32'd4;
      if (!m_started) begin
         pw = 1'b0; iw = 1'b0;
         e_pc_next = RESET_PC;
      end else if (mem_stall_i) begin
         pw = 1'b0; iw = 1'b0; st = 1'b1;
      end else if (m_pending) begin
         e_pc_next = branch_taken_i ? branch_target_i : m_saved;
         fl = 1'b1;
      end else begin
         if (load_use_i) begin
            pw = 1'b0; iw = 1'b0; bb = 1'b1;
         end
         if (branch_taken_i) begin
            e_pc_next = branch_target_i;
            pw = 1'b1; fl = 1'b1;
         end
      end
      e_ctrl = {pw, iw, fl, bb, st};
   endfunction

   function automatic void model_update();
      if (!m_started) begin
         m_started = start_i;
      end else if (mem_stall_i) begin
         if (m_stall < CNT_MAX) m_stall++;
         if (branch_taken_i) begin
            m_pending = 1'b1;
            m_saved   = branch_target_i;
         end
      end else begin
         if ((m_pending || branch_taken_i) && m_flush < CNT_MAX) m_flush++;
         m_pending = 1'b0;
      end
   endfunction

   task automatic check_all();
      check("pc_next", pc_next_o, e_pc_next);
      check("ctrl", 32'({pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o}),
            32'(e_ctrl));
      check("pending", 32'(redirect_pending_o), 32'(m_pending));
      check("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
   endtask

   // Inputs are set just after a rising edge; compare on the falling edge.
   task automatic cycle();
      @(negedge clk_i);
      model_outputs();
      check_all();
      @(posedge clk_i);
      model_update();
      if (e_ctrl[4]) pc_i = e_pc_next;
      #1;
   endtask

   task automatic set_in(input bit ms, input bit lu, input bit br, input logic [31:0] tgt);
      mem_stall_i     = ms;
      load_use_i      = lu;
      branch_taken_i  = br;
      branch_target_i = tgt;
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         start_i = 1'($urandom_range(0, 1));
         set_in(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 15), {$urandom, 2'b00} >> 0);
         if ($urandom_range(0, 9) == 0) pc_i = {$urandom} & 32'hFFFF_FFFC;
         cycle();
      end
   endtask

   initial begin
      model_reset();
      #12;
      @(negedge clk_i);
      model_outputs();
      check_all();   // reset state while rst_i is held
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Start-up: IDLE then sequential fetch with pc_i following pc_next_o
      cycle();
      start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
      end
      check("seq_pc", pc_i, 32'd12);

      // Plain branch redirect
      pc_i = 32'h40;
      set_in(1'b0, 1'b0, 1'b1, 32'h100);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      // Memory stall with a redirect arriving in the second stall cycle
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, (i == 1), 32'h200);
         cycle();
      end
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();
      check("stall_release_pc", pc_i, 32'h200);
      cycle();

      // Load-use hold alone, then resume
      pc_i = 32'h80;
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      // Load-use with coincident branch, and PC wrap
      set_in(1'b0, 1'b1, 1'b1, 32'h300);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      pc_i = 32'hFFFF_FFFC;
      cycle();

      // Long stall to saturate the stall counter; fresh pulse in release cycle
      for (int i = 0; i < 65540; i++) begin
         set_in(1'b1, 1'b0, (i == 10), 32'h400);
         cycle();
      end
      set_in(1'b0, 1'b1, 1'b1, 32'h500);
      cycle();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      random_cycles(3000);

      // Asynchronous reset while a redirect is latched in a stall
      set_in(1'b1, 1'b0, 1'b1, 32'h600);
      cycle();
      set_in(1'b1, 1'b0, 1'b0, 32'h0);
      check("pending_before_rst", 32'(redirect_pending_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      model_reset();
      model_outputs();
      check_all();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      start_i = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();
      random_cycles(500);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that sequences the program counter register and the IF/ID and ID/EX pipeline controls.
- Each cycle it selects the next PC: sequential, redirected, or held.
- It arbitrates between data-memory stall, load-use hazard and branch redirect.
- It latches a redirect that arrives during a memory stall, so the single-cycle redirect pulse is never lost.
- It keeps saturating stall and flush counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value presented on pc_next_o while idle
CNT_W, 16, width of each performance counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  level; leaves IDLE when sampled high
mem_stall_i  in  1  data cache busy; the whole pipeline must freeze
load_use_i  in  1  hazard unit: ID instruction depends on the load in EX
branch_taken_i  in  1  single-cycle pulse from EX; redirect required
branch_target_i  in  32  redirect target, valid only with branch_taken_i
pc_i  in  32  current PC register value
pc_next_o  out  32  value for the PC register to load
pc_write_o  out  1  PC register load enable
ifid_write_o  out  1  IF/ID register load enable
ifid_flush_o  out  1  IF/ID register clear (insert NOP)
idex_bubble_o  out  1  zero ID/EX control fields
pipe_stall_o  out  1  freeze all pipeline registers
redirect_pending_o  out  1  a redirect is latched, waiting for the stall to end
stall_cnt_o  out  CNT_W  cycles spent with mem_stall_i high in RUN/MSTALL
flush_cnt_o  out  CNT_W  redirects applied

Behaviour:
- Reset (rst_i high, asynchronous):
  - state=IDLE, pending=0, saved target=0, both counters=0.
- Output timing:
  - All control outputs are combinational from state, pending and the current inputs (Mealy).
  - Counters and redirect_pending_o are registered.
- Default outputs, unless a rule below overrides:
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_stall_o=0.
  - pc_next_o = pc_i+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IDLE:
  - pc_write_o=0, ifid_write_o=0, pc_next_o=RESET_PC.
  - All other inputs are ignored; a branch pulse in IDLE is dropped.
  - start_i=1 -> RUN next cycle.
  - IDLE is re-entered only by reset; start_i is not sampled outside IDLE.
- RUN, priority mem_stall > load_use > branch:
  - mem_stall_i=1:
    - pipe_stall_o=1, pc_write_o=0, ifid_write_o=0; stall_cnt++; next state MSTALL.
    - If branch_taken_i=1 in the same cycle: save branch_target_i, pending=1.
  - else load_use_i=1:
    - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
    - A coincident branch pulse is still applied: pc_next_o=target, pc_write_o=1, ifid_flush_o=1, flush_cnt++.
    - The EX branch is older than the stalled ID instruction, so it wins over the hold.
  - else branch_taken_i=1:
    - pc_next_o=branch_target_i, ifid_flush_o=1, flush_cnt++.
- MSTALL:
  - While mem_stall_i=1:
    - Freeze as above; stall_cnt++.
    - A new branch pulse overwrites the saved target; pending=1.
  - First cycle with mem_stall_i=0, pending=1:
    - pc_next_o=saved target, pc_write_o=1, ifid_flush_o=1, flush_cnt++, pending cleared.
    - load_use_i is ignored in that cycle because the flush kills the ID instruction.
    - Next state RUN.
  - First cycle with mem_stall_i=0, pending=0:
    - Evaluate exactly as RUN in the same cycle; next state RUN.
  - A fresh branch pulse in the release cycle overrides the saved target; it is the younger redirect.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall discards the pending redirect immediately.

Test Plan:
- Reset then start_i=1 at cycle 2, pc_i tracking pc_next_o: pc_next_o=0 in IDLE with pc_write_o=0; from cycle 3 the sequence is 4, 8, 12 with pc_write_o=1.
- RUN, pc_i=0x40, branch_taken_i pulse with target 0x100: same cycle pc_next_o=0x100, ifid_flush_o=1, flush_cnt_o=1 next cycle.
- mem_stall_i high for 5 cycles with branch pulse (target 0x200) in the 2nd stall cycle:
  - during the stall: pc_write_o=0, pipe_stall_o=1, redirect_pending_o=1;
  - release cycle: pc_next_o=0x200, ifid_flush_o=1;
  - stall_cnt_o=5, pending=0 afterwards.
- load_use_i=1 alone at pc_i=0x80: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; next cycle without hazard pc_next_o=0x84.
- pc_i=32'hFFFF_FFFC, no events: pc_next_o=0. Preload stall_cnt near max via long stall: stall_cnt_o holds at 16'hFFFF.
- rst_i asserted mid-MSTALL with pending=1: outputs return to IDLE values asynchronously, redirect_pending_o=0, counters=0.
